// File: rtl/mc14500_seq_if.sv
// Bus between the MC14500 sequencer, its asynchronous program ROM and the logic unit.
// The sequencer side is the master; the ROM and logic unit side is the slave.
interface mc14500_seq_if;
  logic [7:0]  rom_addr;
  logic [11:0] rom_data;
  logic [3:0]  instruction;
  logic [7:0]  io_addr;
  logic        jmp;
  logic        rtn;
  logic        flg0;
  logic        flgf;

  modport master (
    output rom_addr, instruction, io_addr,
    input  rom_data, jmp, rtn, flg0, flgf
  );

  modport slave (
    input  rom_addr, instruction, io_addr,
    output rom_data, jmp, rtn, flg0, flgf
  );
endinterface

// File: rtl/mc14500_seq.sv
// Program sequencer for an MC14500 logic unit: PC/IR fetch pipeline with one
// delay slot on JMP/RTN, a 4-deep return stack and a saturating NOPO counter.
module mc14500_seq (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  mc14500_seq_if.master       bus,
  output logic                running,
  output logic                stk_ovf,
  output logic                stk_unf,
  output logic [7:0]          flg0_count
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_reg, state_next;
  logic [7:0]      pc_reg;
  logic [7:0]      tgt_reg;
  logic [11:0]     ir_reg;
  logic [2:0]      depth_reg;
  logic            ovf_reg;
  logic            unf_reg;
  logic [7:0]      cnt_reg;
  logic [3:0][7:0] stk_reg;
  logic [3:0][7:0] stk_next;
  logic [3:0][7:0] push_val;
  logic [3:0][7:0] pop_val;

  logic       sel_jmp, sel_rtn;
  logic       push_en, pop_en, load_ir;
  logic       stack_empty, shift_pop;
  logic [7:0] stack_top;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // jmp/rtn steer the fetch address even on the flgf edge, but only move the stack when not ending.
  always_comb begin
    state_next = state_reg;
    running    = 1'b0;
    load_ir    = 1'b0;
    sel_jmp    = 1'b0;
    sel_rtn    = 1'b0;
    push_en    = 1'b0;
    pop_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          load_ir    = 1'b1;
        end
      end
      RUN: begin
        running = 1'b1;
        sel_jmp = bus.jmp;
        sel_rtn = bus.rtn & ~bus.jmp;
        if (bus.flgf) begin
          state_next = IDLE;
        end else begin
          load_ir = 1'b1;
          push_en = sel_jmp;
          pop_en  = sel_rtn;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign stack_empty     = (depth_reg == 3'd0);
  assign stack_top       = stack_empty ? 8'd0 : stk_reg[0];
  assign shift_pop       = pop_en & ~stack_empty;
  assign bus.rom_addr    = sel_jmp ? tgt_reg : (sel_rtn ? stack_top : pc_reg);
  assign bus.instruction = ir_reg[11:8];
  assign bus.io_addr     = ir_reg[7:0];

  // Entry 0 is the top; a push shifts everything down so the oldest entry falls off the end.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_stack
      if (gi == 0) begin : g_top
        assign push_val[gi] = pc_reg;
      end else begin : g_below
        assign push_val[gi] = stk_reg[gi-1];
      end
      if (gi == 3) begin : g_bottom
        assign pop_val[gi] = 8'd0;
      end else begin : g_above
        assign pop_val[gi] = stk_reg[gi+1];
      end
      assign stk_next[gi] = push_en   ? push_val[gi] :
                            shift_pop ? pop_val[gi]  : stk_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg    <= 8'd0;
      tgt_reg   <= 8'd0;
      ir_reg    <= 12'd0;
      depth_reg <= 3'd0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
      cnt_reg   <= 8'd0;
      stk_reg   <= '0;
    end else begin
      tgt_reg <= ir_reg[7:0];
      stk_reg <= stk_next;
      if (load_ir) begin
        ir_reg <= bus.rom_data;
        pc_reg <= bus.rom_addr + 8'd1;
      end else if (state_reg == RUN) begin
        ir_reg <= 12'd0;
        pc_reg <= 8'd0;
      end
      if (running && bus.flg0 && (cnt_reg != 8'hFF)) begin
        cnt_reg <= cnt_reg + 8'd1;
      end
      if (push_en) begin
        if (depth_reg == 3'd4) ovf_reg   <= 1'b1;
        else                   depth_reg <= depth_reg + 3'd1;
      end else if (pop_en) begin
        if (stack_empty) unf_reg   <= 1'b1;
        else             depth_reg <= depth_reg - 3'd1;
      end
    end
  end

  assign stk_ovf    = ovf_reg;
  assign stk_unf    = unf_reg;
  assign flg0_count = cnt_reg;

endmodule

// File: tb/tb_mc14500_seq.sv
// Bench for mc14500_seq: vector table, directed stack/reset sequences, and
// randomized stimulus checked against a queue-based reference model.
module tb_mc14500_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       running;
  logic       stk_ovf;
  logic       stk_unf;
  logic [7:0] flg0_count;

  mc14500_seq_if bus();

  logic [11:0] rom [256];
  assign bus.rom_data = rom[bus.rom_addr];

  mc14500_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .running    (running),
    .stk_ovf    (stk_ovf),
    .stk_unf    (stk_unf),
    .flg0_count (flg0_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0] in_bits;   // start, jmp, rtn, flg0, flgf
    logic [7:0] addr;
    logic [3:0] ins;
    logic [2:0] flags;     // running, stk_ovf, stk_unf
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl [19];

  int         ov_op   [13] = '{1, 0, 2, 2, 2, 2, 2, 3, 3, 3, 3, 3, 0};
  logic [7:0] ov_addr [13] = '{8'h00, 8'h01, 8'h30, 8'h31, 8'h60, 8'h61, 8'h90,
                               8'h62, 8'h61, 8'h32, 8'h31, 8'h00, 8'h01};

  // Reference model state
  bit         m_run;
  logic [7:0] m_pc, m_tgt;
  logic [11:0] m_ir;
  logic [7:0] m_stk [$];
  int         m_cnt;
  bit         m_ovf, m_unf;

  function automatic vec_t mk(input logic [4:0] i, input logic [7:0] a,
                              input logic [3:0] n, input logic [2:0] f,
                              input logic [7:0] c);
    vec_t v;
    v.in_bits = i; v.addr = a; v.ins = n; v.flags = f; v.cnt = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic r, input logic s, input logic j,
                        input logic t, input logic f0, input logic ff);
    reset = r; start = s; bus.jmp = j; bus.rtn = t; bus.flg0 = f0; bus.flgf = ff;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " rom_addr"}, 32'(bus.rom_addr), 32'h0);
    chk({tag, " instruction"}, 32'(bus.instruction), 32'h0);
    chk({tag, " io_addr"}, 32'(bus.io_addr), 32'h0);
    chk({tag, " running"}, 32'(running), 32'h0);
    chk({tag, " stk_ovf"}, 32'(stk_ovf), 32'h0);
    chk({tag, " stk_unf"}, 32'(stk_unf), 32'h0);
    chk({tag, " flg0_count"}, 32'(flg0_count), 32'h0);
  endtask

  function automatic logic [7:0] model_addr();
    if (m_run && bus.jmp) return m_tgt;
    if (m_run && bus.rtn) return (m_stk.size() == 0) ? 8'h00 : m_stk[0];
    return m_pc;
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_pc = 8'd0; m_tgt = 8'd0; m_ir = 12'd0;
    m_stk.delete(); m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  // Advance the model by one clock edge given the inputs seen before the edge.
  task automatic model_step(input logic [7:0] a);
    logic [7:0] nt;
    if (reset) begin
      model_reset();
    end else begin
      nt = m_ir[7:0];
      if (!m_run) begin
        if (start) begin
          m_run = 1'b1; m_ir = rom[a]; m_pc = a + 8'd1;
        end
      end else begin
        if (bus.flg0 && m_cnt < 255) m_cnt++;
        if (bus.flgf) begin
          m_run = 1'b0; m_pc = 8'd0; m_ir = 12'd0;
        end else begin
          m_ir = rom[a];
          if (bus.jmp) begin
            if (m_stk.size() == 4) begin
              void'(m_stk.pop_back());
              m_ovf = 1'b1;
            end
            m_stk.push_front(m_pc);
          end else if (bus.rtn) begin
            if (m_stk.size() == 0) m_unf = 1'b1;
            else void'(m_stk.pop_front());
          end
          m_pc = a + 8'd1;
        end
      end
      m_tgt = nt;
    end
  endtask

  initial begin
    logic [7:0] ea;
    for (int i = 0; i < 256; i++) rom[i] = 12'h000;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_reset_outputs("reset");
    $display("reset: addr=%02h ins=%h run=%b", bus.rom_addr, bus.instruction, running);

    // Straight-line, jump, return, underflow, end and restart
    rom[0] = 12'h10A; rom[1] = 12'h30B; rom[2] = 12'h50C; rom[3] = 12'h80D;
    rom[4] = 12'h000; rom[5] = 12'hC20; rom[6] = 12'h206; rom[7] = 12'h407;
    rom[8] = 12'h708; rom[8'h20] = 12'h921; rom[8'h21] = 12'hD00; rom[8'h22] = 12'h622;
    tbl[0]  = mk(5'b10000, 8'h00, 4'h0, 3'b000, 8'd0);
    tbl[1]  = mk(5'b00000, 8'h01, 4'h1, 3'b100, 8'd0);
    tbl[2]  = mk(5'b00000, 8'h02, 4'h3, 3'b100, 8'd0);
    tbl[3]  = mk(5'b00000, 8'h03, 4'h5, 3'b100, 8'd0);
    tbl[4]  = mk(5'b00000, 8'h04, 4'h8, 3'b100, 8'd0);
    tbl[5]  = mk(5'b00000, 8'h05, 4'h0, 3'b100, 8'd0);
    tbl[6]  = mk(5'b00000, 8'h06, 4'hC, 3'b100, 8'd0);
    tbl[7]  = mk(5'b01000, 8'h20, 4'h2, 3'b100, 8'd0);
    tbl[8]  = mk(5'b00000, 8'h21, 4'h9, 3'b100, 8'd0);
    tbl[9]  = mk(5'b00000, 8'h22, 4'hD, 3'b100, 8'd0);
    tbl[10] = mk(5'b00100, 8'h07, 4'h6, 3'b100, 8'd0);
    tbl[11] = mk(5'b00000, 8'h08, 4'h4, 3'b100, 8'd0);
    tbl[12] = mk(5'b00100, 8'h00, 4'h7, 3'b100, 8'd0);
    tbl[13] = mk(5'b00000, 8'h01, 4'h1, 3'b101, 8'd0);
    tbl[14] = mk(5'b00010, 8'h02, 4'h3, 3'b101, 8'd0);
    tbl[15] = mk(5'b01001, 8'h0B, 4'h5, 3'b101, 8'd1);
    tbl[16] = mk(5'b00000, 8'h00, 4'h0, 3'b001, 8'd1);
    tbl[17] = mk(5'b11000, 8'h00, 4'h0, 3'b001, 8'd1);
    tbl[18] = mk(5'b00000, 8'h01, 4'h1, 3'b101, 8'd1);

    for (int r = 0; r < 19; r++) begin
      set_in(1'b0, tbl[r].in_bits[4], tbl[r].in_bits[3], tbl[r].in_bits[2],
             tbl[r].in_bits[1], tbl[r].in_bits[0]);
      #1;
      $display("vec %0d: in=%b addr=%02h ins=%h run=%b ovf=%b unf=%b cnt=%0d", r,
               tbl[r].in_bits, bus.rom_addr, bus.instruction, running, stk_ovf, stk_unf, flg0_count);
      chk($sformatf("vec%0d rom_addr", r), 32'(bus.rom_addr), 32'(tbl[r].addr));
      chk($sformatf("vec%0d instruction", r), 32'(bus.instruction), 32'(tbl[r].ins));
      chk($sformatf("vec%0d running", r), 32'(running), 32'(tbl[r].flags[2]));
      chk($sformatf("vec%0d stk_ovf", r), 32'(stk_ovf), 32'(tbl[r].flags[1]));
      chk($sformatf("vec%0d stk_unf", r), 32'(stk_unf), 32'(tbl[r].flags[0]));
      chk($sformatf("vec%0d flg0_count", r), 32'(flg0_count), 32'(tbl[r].cnt));
      tick();
    end

    // Overflow: five pushes, then four pops newest-first and one underflow
    for (int i = 0; i < 256; i++) begin
      ea = 8'(i + 8'h30);
      rom[i] = {4'(i), ea};
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 13; c++) begin
      set_in(1'b0, ov_op[c] == 1, ov_op[c] == 2, ov_op[c] == 3, 1'b0, 1'b0);
      #1;
      $display("ovf %0d: op=%0d addr=%02h ovf=%b unf=%b", c, ov_op[c], bus.rom_addr, stk_ovf, stk_unf);
      chk($sformatf("ovf%0d rom_addr", c), 32'(bus.rom_addr), 32'(ov_addr[c]));
      chk($sformatf("ovf%0d stk_ovf", c), 32'(stk_ovf), 32'(c >= 7));
      chk($sformatf("ovf%0d stk_unf", c), 32'(stk_unf), 32'(c == 12));
      tick();
    end

    // Reset in the middle of a run with jmp high and the counter saturated
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      if (i == 100) chk("flg0_count at 100", 32'(flg0_count), 32'd100);
      tick();
    end
    $display("sat: flg0_count=%0d running=%b", flg0_count, running);
    chk("flg0_count saturated", 32'(flg0_count), 32'd255);
    chk("running before reset", 32'(running), 32'd1);
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    $display("midreset: addr=%02h ins=%h run=%b cnt=%0d", bus.rom_addr, bus.instruction, running, flg0_count);
    chk_reset_outputs("midreset");

    // Randomized run against the reference model
    for (int i = 0; i < 256; i++) rom[i] = 12'($urandom);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    tick();
    for (int c = 0; c < 1500; c++) begin
      set_in($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0);
      #1;
      ea = model_addr();
      $display("rnd %0d: in=%b%b%b%b%b%b addr=%02h ins=%h run=%b cnt=%0d", c, reset, start,
               bus.jmp, bus.rtn, bus.flg0, bus.flgf, bus.rom_addr, bus.instruction, running, flg0_count);
      chk($sformatf("rnd%0d rom_addr", c), 32'(bus.rom_addr), 32'(ea));
      chk($sformatf("rnd%0d instruction", c), 32'(bus.instruction), 32'(m_ir[11:8]));
      chk($sformatf("rnd%0d io_addr", c), 32'(bus.io_addr), 32'(m_ir[7:0]));
      chk($sformatf("rnd%0d running", c), 32'(running), 32'(m_run));
      chk($sformatf("rnd%0d stk_ovf", c), 32'(stk_ovf), 32'(m_ovf));
      chk($sformatf("rnd%0d stk_unf", c), 32'(stk_unf), 32'(m_unf));
      chk($sformatf("rnd%0d flg0_count", c), 32'(flg0_count), 32'(m_cnt));
      @(posedge clk);
      model_step(ea);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
